lms_tap_update_seq: RTL and testbench

Sequential tap-weight update engine for the adaptive filter. It latches an error sample and encodes its magnitude into a 3-bit power-of-two shift code plus a sign. It then accepts the 15 per-tap update words (taps 2..16) one at a time over a valid/ready stream, shifts each one, and accumulates the result into an internal 15-entry weight register file. This is the producer side of the barrel-shift path: it chooses the shift code that the parallel shifter bank only applies, and it time-multiplexes one shifter instead of fifteen.

---
 rtl/lms_tap_update_seq_if.sv | 19 +
 rtl/lms_tap_update_seq.sv | 173 +++++++++++++++++
 tb/tb_lms_tap_update_seq.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lms_tap_update_seq_if.sv
// Update-word stream between the tap-word producer and the LMS update engine.
// Latency: n/a (wires only).
// Backpressure: a word moves on a cycle with a_vld & a_rdy; the producer holds a_data while a_rdy is low.
//
// Signals:
//   a_vld  - producer has an update word
//   a_data - update word for the current tap (two's complement, DW bits)
//   a_rdy  - engine accepts the word this cycle
// Modports: master (producer), slave (engine).
interface lms_tap_update_seq_if #(
  parameter int DW = 10
);
  logic          a_vld;
  logic [DW-1:0] a_data;
  logic          a_rdy;

  modport master (output a_vld, output a_data, input  a_rdy);
  modport slave  (input  a_vld, input  a_data, output a_rdy);
endinterface

// File: rtl/lms_tap_update_seq.sv
// LMS tap-weight update engine: encodes |err| into a power-of-two shift and accumulates shifted update words into 15 weights.
// Latency: start to done is 17 cycles minimum (1 ENC cycle, 15 RUN accepts, 1 DONE cycle); weight writes show on rd_w_o the next cycle.
// Backpressure: a_rdy is high only in RUN; gaps in a_vld stall the pass indefinitely.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start_i, err_i    - begin a pass (sampled in IDLE only), error sample latched with it
//   a_if (slave)      - update-word stream, taps 2..16 in order
//   wr_en_i/wr_idx_i/wr_data_i - weight preload, honoured in IDLE only, index 15 ignored
//   rd_idx_i, rd_w_o  - combinational weight read, 0 for index 15
//   busy_o, done_o    - busy in ENC/RUN, one-cycle done pulse
//   sh_o, neg_o       - latched shift code and error sign
// Configuration: define LMS_SAT_EN to clamp weight sums; otherwise sums wrap modulo 2^DW.
module lms_tap_update_seq #(
  parameter int DW   = 10,
  parameter int NTAP = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [DW-1:0]        err_i,
  lms_tap_update_seq_if.slave  a_if,
  input  logic                 wr_en_i,
  input  logic [3:0]           wr_idx_i,
  input  logic [DW-1:0]        wr_data_i,
  input  logic [3:0]           rd_idx_i,
  output logic [DW-1:0]        rd_w_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           sh_o,
  output logic                 neg_o
);

  localparam logic [3:0] LAST_IDX = 4'(NTAP - 1);

`ifdef LMS_SAT_EN
  // One guard bit so the clamp can see the true sum.
  localparam int SW = DW + 1;
  localparam logic signed [SW-1:0] WMAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] WMIN = {2'b11, {(DW-1){1'b0}}};
`else
  // Wrapping keeps only the low DW bits, which the guard bit never affects.
  localparam int SW = DW;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;

  logic [DW-1:0] err_q;
  logic [2:0]    sh_q, sh_d;
  logic          neg_q;
  logic          zero_q;
  logic [3:0]    idx_q;
  logic [DW-1:0] w_q [NTAP];

  logic [DW-1:0] mag;
  logic [3:0]    lead;
  logic          acc;
  logic          wr_ok;

  logic signed [SW-1:0] a_ext;
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] w_ext;
  logic signed [SW-1:0] sum;
  logic [DW-1:0]        w_new;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_ENC;
      S_ENC:  state_d = S_RUN;
      S_RUN:  if (acc && (idx_q == LAST_IDX)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    a_if.a_rdy = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      S_ENC:  busy_o = 1'b1;
      S_RUN:  begin busy_o = 1'b1; a_if.a_rdy = 1'b1; end
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  assign acc   = (state_q == S_RUN) && a_if.a_vld;
  assign wr_ok = (state_q == S_IDLE) && !start_i && wr_en_i && (wr_idx_i <= LAST_IDX);

  // ---------------- Error encoder ----------------
  always_comb begin
    mag = err_q[DW-1] ? (~err_q + 1'b1) : err_q;
    // The most negative value has no positive twin; clamp it.
    if (err_q == {1'b1, {(DW-1){1'b0}}}) mag = {1'b0, {(DW-1){1'b1}}};
    lead = 4'd0;
    for (int i = 0; i < DW; i++) begin
      if (mag[i]) lead = 4'(i);
    end
    // A zero magnitude leaves lead at 0; the zero flag masks every delta anyway.
    if (lead >= 4'd7) sh_d = 3'd0;
    else              sh_d = 3'd7 - lead[2:0];
  end

  // ---------------- Shift / accumulate datapath ----------------
  always_comb begin
    a_ext   = SW'($signed(a_if.a_data));
    shifted = a_ext >>> sh_q;
    delta   = zero_q ? '0 : (neg_q ? -shifted : shifted);
    w_ext   = SW'($signed(w_q[idx_q]));
    sum     = w_ext + delta;
`ifdef LMS_SAT_EN
    if (sum > WMAX)      w_new = WMAX[DW-1:0];
    else if (sum < WMIN) w_new = WMIN[DW-1:0];
    else                 w_new = sum[DW-1:0];
`else
    w_new = sum[DW-1:0];
`endif
  end

  // ---------------- Control registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= '0;
      sh_q   <= '0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      if ((state_q == S_IDLE) && start_i) err_q <= err_i;
      if (state_q == S_ENC) begin
        sh_q   <= sh_d;
        neg_q  <= err_q[DW-1];
        zero_q <= (mag == '0);
      end
      // idx wraps straight back to 0 on the final accept, so it never points past the file.
      if (acc) idx_q <= (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
      else if (state_q == S_DONE) idx_q <= '0;
    end
  end

  // ---------------- Weight register file ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) w_q[i] <= '0;
    end else begin
      if (wr_ok) w_q[wr_idx_i] <= wr_data_i;
      if (acc)   w_q[idx_q]    <= w_new;
    end
  end

  assign rd_w_o = (rd_idx_i <= LAST_IDX) ? w_q[rd_idx_i] : '0;
  assign sh_o   = sh_q;
  assign neg_o  = neg_q;

endmodule

// File: tb/tb_lms_tap_update_seq.sv
module tb_lms_tap_update_seq;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] err;
  logic          wr_en;
  logic [3:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic [3:0]    rd_idx;
  logic [DW-1:0] rd_w;
  logic          busy;
  logic          done;
  logic [2:0]    sh;
  logic          neg;

  int n_chk  = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  logic [DW-1:0] data_v [15];
  logic [DW-1:0] exp_w  [15];

  lms_tap_update_seq_if #(.DW(DW)) a_if ();

  lms_tap_update_seq #(.DW(DW), .NTAP(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .err_i     (err),
    .a_if      (a_if.slave),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data),
    .rd_idx_i  (rd_idx),
    .rd_w_o    (rd_w),
    .busy_o    (busy),
    .done_o    (done),
    .sh_o      (sh),
    .neg_o     (neg)
  );

  always #5 clk = ~clk;

  // Handshake and done-pulse monitor.
  always @(posedge clk) begin
    if (a_if.a_vld && a_if.a_rdy) acc_cnt++;
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input int i, output logic [DW-1:0] v);
    rd_idx = 4'(i);
    #1;
    v = rd_w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic preload(input int i, input logic [DW-1:0] v);
    wr_en = 1'b1; wr_idx = 4'(i); wr_data = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic clear_vectors();
    for (int i = 0; i < 15; i++) begin
      data_v[i] = '0;
      exp_w[i]  = '0;
    end
  endtask

  task automatic check_weights(input string tag);
    logic [DW-1:0] v;
    for (int i = 0; i < 15; i++) begin
      peek(i, v);
      n_chk++;
      if (v !== exp_w[i]) begin
        n_fail++;
        $display("FAIL %s_w%0d: got %0d want %0d", tag, i, $signed(v), $signed(exp_w[i]));
      end
    end
  endtask

  // One pass: start with error e, feed data_v; optional 3-cycle a_vld gap before word gap_at,
  // during which start and a preload strobe are also driven (both must be ignored).
  task automatic run_pass(input string tag, input logic [DW-1:0] e, input logic [2:0] exp_sh,
                          input logic exp_neg, input int gap_at);
    int k, guard, gaps_left, acc0, done0;
    logic was_acc;
    acc0 = acc_cnt; done0 = done_cnt;
    gaps_left = (gap_at >= 0) ? 3 : 0;
    start = 1'b1; err = e;
    step();
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || a_if.a_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_enc: got busy=%b a_rdy=%b want busy=1 a_rdy=0", tag, busy, a_if.a_rdy);
    end
    step();
    n_chk++;
    if (a_if.a_rdy !== 1'b1 || sh !== exp_sh || neg !== exp_neg) begin
      n_fail++;
      $display("FAIL %s_run: got a_rdy=%b sh=%0d neg=%b want a_rdy=1 sh=%0d neg=%b",
               tag, a_if.a_rdy, sh, neg, exp_sh, exp_neg);
    end
    k = 0; guard = 0;
    while (k < 15 && guard < 200) begin
      if (k == gap_at && gaps_left > 0) begin
        a_if.a_vld = 1'b0;
        start = 1'b1;
        wr_en = 1'b1; wr_idx = 4'd3; wr_data = 10'd99;
        gaps_left--;
      end else begin
        a_if.a_vld = 1'b1; a_if.a_data = data_v[k];
        start = 1'b0; wr_en = 1'b0;
      end
      was_acc = a_if.a_vld && a_if.a_rdy;
      step();
      if (was_acc) k++;
      guard++;
    end
    a_if.a_vld = 1'b0; start = 1'b0; wr_en = 1'b0;
    n_chk++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d accepts want 15", tag, k);
    end
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || a_if.a_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: got done=%b busy=%b a_rdy=%b want 1 0 0", tag, done, busy, a_if.a_rdy);
    end
    step();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: got done=%b busy=%b want 0 0", tag, done, busy);
    end
    n_chk++;
    if ((acc_cnt - acc0) != 15 || (done_cnt - done0) != 1) begin
      n_fail++;
      $display("FAIL %s_counts: got accepts=%0d dones=%0d want 15 1", tag, acc_cnt - acc0, done_cnt - done0);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    do_reset();
    preload(15, 10'd123);  // index 15 is not a weight; must be dropped
    for (int i = 0; i < 16; i++) begin
      peek(i, v);
      n_chk++;
      if (v !== '0) begin
        n_fail++;
        $display("FAIL reset_w%0d: got %0d want 0", i, $signed(v));
      end
    end
    n_chk++;
    if (busy !== 1'b0 || a_if.a_rdy !== 1'b0 || done !== 1'b0 || sh !== 3'd0 || neg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b a_rdy=%b done=%b sh=%0d neg=%b want all 0",
               busy, a_if.a_rdy, done, sh, neg);
    end
  endtask

  // err=+64: lead 6, sh 1. 10 + (100>>>1) = 60.
  task automatic test_shift_update();
    do_reset();
    clear_vectors();
    preload(0, 10'd10);
    data_v[0] = 10'd100;
    exp_w[0]  = 10'd60;
    run_pass("shift", 10'd64, 3'd1, 1'b0, -1);
    check_weights("shift");
  endtask

  // err=-3: mag 3, lead 1, sh 6. -128>>>6 = -2 -> +2; 64>>>6 = 1 -> -1.
  task automatic test_negative_err();
    do_reset();
    clear_vectors();
    data_v[0] = 10'h380;  // -128
    data_v[1] = 10'd64;
    exp_w[0]  = 10'd2;
    exp_w[1]  = 10'h3FF;  // -1
    run_pass("neg", 10'h3FD, 3'd6, 1'b1, -1);
    check_weights("neg");
  endtask

  // err=+128: sh 0, each word 8 adds 8; gap, stray start and stray preload mid-stream.
  task automatic test_handshake();
    do_reset();
    clear_vectors();
    for (int i = 0; i < 15; i++) begin
      data_v[i] = 10'd8;
      exp_w[i]  = 10'd8;
    end
    run_pass("hs", 10'd128, 3'd0, 1'b0, 5);
    step();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_start_queued: got busy=%b want 0", busy);
    end
    check_weights("hs");
  endtask

  // 500 + 511: clamps to 511, or wraps to -13.
  task automatic test_overflow();
    do_reset();
    clear_vectors();
    preload(0, 10'd500);
    data_v[0] = 10'd511;
`ifdef LMS_SAT_EN
    exp_w[0] = 10'd511;
`else
    exp_w[0] = 10'h3F3;
`endif
    run_pass("ovf", 10'd200, 3'd0, 1'b0, -1);
    check_weights("ovf");
  endtask

  // err=0 leaves weights alone; the next start goes in the cycle after done.
  task automatic test_zero_err_back_to_back();
    do_reset();
    clear_vectors();
    preload(2, 10'd77);
    for (int i = 0; i < 15; i++) data_v[i] = 10'd100;
    exp_w[2] = 10'd77;
    run_pass("zero", 10'd0, 3'd7, 1'b0, -1);
    check_weights("zero");
    for (int i = 0; i < 15; i++) data_v[i] = '0;
    data_v[0] = 10'd2;   // err=+64 -> sh 1 -> +1
    exp_w[0]  = 10'd1;
    run_pass("b2b", 10'd64, 3'd1, 1'b0, -1);
    check_weights("b2b");
  endtask

  task automatic test_reset_mid_pass();
    logic [DW-1:0] v;
    do_reset();
    clear_vectors();
    start = 1'b1; err = 10'd128;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      a_if.a_vld = 1'b1; a_if.a_data = 10'd8;
      step();
    end
    a_if.a_vld = 1'b0;
    peek(4, v);
    n_chk++;
    if (v !== 10'd8 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got w4=%0d busy=%b want 8 1", $signed(v), busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || a_if.a_rdy !== 1'b0 || done !== 1'b0 || sh !== 3'd0) begin
      n_fail++;
      $display("FAIL rstmid_ctrl: got busy=%b a_rdy=%b done=%b sh=%0d want 0 0 0 0",
               busy, a_if.a_rdy, done, sh);
    end
    check_weights("rstmid");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; err = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
    a_if.a_vld = 1'b0; a_if.a_data = '0;
    test_reset();
    test_shift_update();
    test_negative_err();
    test_handshake();
    test_overflow();
    test_zero_err_back_to_back();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
